neuron_layer_sequencer: RTL and testbench

- Time-multiplexes one combinational `neuron` datapath across N_NEURONS logical neurons. Sits directly upstream and downstream of that datapath.
- Holds per-neuron configuration (weights, threshold, decay shift), membrane potentials and last-spike bits in registers.
- Per accepted timestep: feeds each neuron's state to the datapath in turn, writes back `new_membrane`/`is_spike`, and emits one spike vector through a valid/ready handshake.

---
 rtl/neuron_pkg.sv | 24 ++
 rtl/neuron_cfg_regfile.sv | 41 ++++
 rtl/neuron_layer_sequencer.sv | 131 +++++++++++++
 tb/tb_neuron_layer_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared sizing, cfg-word field layout and FSM state type for the neuron layer sequencer.
package neuron_pkg;
  localparam int N_STAGE     = 3;
  localparam int N_INPUTS    = 2 ** N_STAGE;
  localparam int N_MEMBRANE  = N_STAGE + 2;
  localparam int N_THRESHOLD = N_MEMBRANE - 1;
  localparam int N_NEURONS   = 4;
  localparam int SHIFT_W     = 3;
  localparam int CFG_W       = N_INPUTS + N_THRESHOLD + SHIFT_W;
  localparam int ADDR_W      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;

  // cfg word layout: {weights, threshold, shift}, shift in the LSBs
  localparam int CFG_SHIFT_LSB = 0;
  localparam int CFG_THR_LSB   = SHIFT_W;
  localparam int CFG_WGT_LSB   = SHIFT_W + N_THRESHOLD;

  localparam logic [N_THRESHOLD-1:0] THRESHOLD_RST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/neuron_cfg_regfile.sv
// Per-neuron weights/threshold/shift storage: one synchronous write port and one
// combinational read port. Writes to addresses >= N_NEURONS match no entry and are dropped.
module neuron_cfg_regfile
  import neuron_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_waddr,
  input  logic [CFG_W-1:0]       i_wdata,
  input  logic [ADDR_W-1:0]      i_raddr,
  output logic [N_INPUTS-1:0]    o_weights,
  output logic [N_THRESHOLD-1:0] o_threshold,
  output logic [SHIFT_W-1:0]     o_shift
);
  logic [N_INPUTS-1:0]    r_weights   [N_NEURONS];
  logic [N_THRESHOLD-1:0] r_threshold [N_NEURONS];
  logic [SHIFT_W-1:0]     r_shift     [N_NEURONS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_weights[i]   <= '0;
        r_threshold[i] <= THRESHOLD_RST;
        r_shift[i]     <= '0;
      end
    end else if (i_we) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (i_waddr == ADDR_W'(i)) begin
          r_weights[i]   <= i_wdata[CFG_WGT_LSB +: N_INPUTS];
          r_threshold[i] <= i_wdata[CFG_THR_LSB +: N_THRESHOLD];
          r_shift[i]     <= i_wdata[CFG_SHIFT_LSB +: SHIFT_W];
        end
      end
    end
  end

  assign o_weights   = r_weights[i_raddr];
  assign o_threshold = r_threshold[i_raddr];
  assign o_shift     = r_shift[i_raddr];
endmodule

// File: rtl/neuron_layer_sequencer.sv
// Time-multiplexes one external combinational neuron datapath over N_NEURONS neurons.
// Optional macro SPIKE_COUNTER_EN adds a saturating spike_count output.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never
// depends on ready, and out_valid/out_spikes hold steady until accepted.
module neuron_layer_sequencer
  import neuron_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ADDR_W-1:0]      cfg_addr,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic                   clear,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [N_INPUTS-1:0]    step_inputs,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_NEURONS-1:0]   out_spikes,
  output logic [1:0]             dbg_state,
  output logic [N_INPUTS-1:0]    nrn_inputs,
  output logic [N_INPUTS-1:0]    nrn_weights,
  output logic [SHIFT_W-1:0]     nrn_shift,
  output logic [N_THRESHOLD-1:0] nrn_threshold,
  output logic [N_MEMBRANE-1:0]  nrn_last_membrane,
  output logic                   nrn_was_spike,
  input  logic [N_MEMBRANE-1:0]  nrn_new_membrane,
  input  logic                   nrn_is_spike
`ifdef SPIKE_COUNTER_EN
  ,
  output logic [7:0]             spike_count
`endif
);
  state_t                r_state, w_next_state;
  logic [ADDR_W-1:0]     r_idx;
  logic [N_INPUTS-1:0]   r_inputs;
  logic [N_MEMBRANE-1:0] r_membrane [N_NEURONS];
  logic [N_NEURONS-1:0]  r_was_spike;
  logic [N_NEURONS-1:0]  r_out_spikes;
  logic                  r_out_valid;
  logic                  w_eval, w_last, w_cfg_we, w_step_acc;
  logic [ADDR_W-1:0]     w_rd_idx;

  assign w_eval     = (r_state == EVAL);
  assign w_last     = (r_idx == ADDR_W'(N_NEURONS - 1));
  assign cfg_ready  = (r_state == IDLE) && !clear;
  assign step_ready = cfg_ready && !cfg_valid;
  assign w_cfg_we   = cfg_valid && cfg_ready;
  assign w_step_acc = step_valid && step_ready;
  assign out_valid  = r_out_valid;
  assign out_spikes = r_out_spikes;
  assign dbg_state  = r_state;

  // Outside EVAL the datapath sees neuron 0 with zero inputs and its result is discarded.
  assign w_rd_idx          = w_eval ? r_idx : '0;
  assign nrn_inputs        = w_eval ? r_inputs : '0;
  assign nrn_last_membrane = r_membrane[w_rd_idx];
  assign nrn_was_spike     = r_was_spike[w_rd_idx];

  neuron_cfg_regfile u_cfg (
    .clk         (clk),
    .reset       (reset),
    .i_we        (w_cfg_we),
    .i_waddr     (cfg_addr),
    .i_wdata     (cfg_data),
    .i_raddr     (w_rd_idx),
    .o_weights   (nrn_weights),
    .o_threshold (nrn_threshold),
    .o_shift     (nrn_shift)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_step_acc) w_next_state = EVAL;
      EVAL:    if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) r_membrane[i] <= '0;
      r_was_spike  <= '0;
      r_inputs     <= '0;
      r_idx        <= '0;
      r_out_spikes <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (clear) begin
            for (int i = 0; i < N_NEURONS; i++) r_membrane[i] <= '0;
            r_was_spike <= '0;
          end else if (w_step_acc) begin
            r_inputs <= step_inputs;
            r_idx    <= '0;
          end
        end
        EVAL: begin
          r_membrane[r_idx]   <= nrn_new_membrane;
          r_was_spike[r_idx]  <= nrn_is_spike;
          r_out_spikes[r_idx] <= nrn_is_spike;
          if (w_last) r_out_valid <= 1'b1;
          else        r_idx <= r_idx + 1'b1;
        end
        DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef SPIKE_COUNTER_EN
  logic [7:0] r_spike_count;

  always_ff @(posedge clk) begin
    if (reset || (r_state == IDLE && clear)) r_spike_count <= '0;
    else if (w_eval && nrn_is_spike && r_spike_count != 8'hFF)
      r_spike_count <= r_spike_count + 8'd1;
  end

  assign spike_count = r_spike_count;
`endif
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench for neuron_layer_sequencer with a behavioural neuron datapath.
`timescale 1ns/1ps
module tb_neuron_layer_sequencer;
  import neuron_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cfg_valid = 1'b0, cfg_ready;
  logic [ADDR_W-1:0]      cfg_addr = '0;
  logic [CFG_W-1:0]       cfg_data = '0;
  logic                   clear = 1'b0;
  logic                   step_valid = 1'b0, step_ready;
  logic [N_INPUTS-1:0]    step_inputs = '0;
  logic                   out_valid, out_ready = 1'b0;
  logic [N_NEURONS-1:0]   out_spikes;
  logic [1:0]             dbg_state;
  logic [N_INPUTS-1:0]    nrn_inputs, nrn_weights;
  logic [SHIFT_W-1:0]     nrn_shift;
  logic [N_THRESHOLD-1:0] nrn_threshold;
  logic [N_MEMBRANE-1:0]  nrn_last_membrane, nrn_new_membrane;
  logic                   nrn_was_spike, nrn_is_spike;
  logic [N_MEMBRANE:0]    w_nrn_out;
`ifdef SPIKE_COUNTER_EN
  logic [7:0]             spike_count;
`endif

  always #5 clk = ~clk;

  neuron_layer_sequencer dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .clear(clear),
    .step_valid(step_valid), .step_ready(step_ready), .step_inputs(step_inputs),
    .out_valid(out_valid), .out_ready(out_ready), .out_spikes(out_spikes),
    .dbg_state(dbg_state),
    .nrn_inputs(nrn_inputs), .nrn_weights(nrn_weights), .nrn_shift(nrn_shift),
    .nrn_threshold(nrn_threshold), .nrn_last_membrane(nrn_last_membrane),
    .nrn_was_spike(nrn_was_spike), .nrn_new_membrane(nrn_new_membrane),
    .nrn_is_spike(nrn_is_spike)
`ifdef SPIKE_COUNTER_EN
    , .spike_count(spike_count)
`endif
  );

  // Behavioural neuron: reset-after-spike, leak by arithmetic shift, add matching
  // weighted inputs, saturate to the signed membrane range, spike at >= threshold.
  function automatic logic [N_MEMBRANE:0] nrn_model(
    input logic [N_INPUTS-1:0] in, input logic [N_INPUTS-1:0] w,
    input logic [SHIFT_W-1:0] sh, input logic [N_THRESHOLD-1:0] thr,
    input logic signed [N_MEMBRANE-1:0] last, input logic was);
    int m;
    m = was ? 0 : (int'(last) >>> sh);
    m = m + $countones(in & w);
    if (m > (2 ** (N_MEMBRANE - 1)) - 1) m = (2 ** (N_MEMBRANE - 1)) - 1;
    if (m < -(2 ** (N_MEMBRANE - 1))) m = -(2 ** (N_MEMBRANE - 1));
    return {(m >= int'(thr)), N_MEMBRANE'(m)};
  endfunction

  always_comb w_nrn_out = nrn_model(nrn_inputs, nrn_weights, nrn_shift, nrn_threshold,
                                    nrn_last_membrane, nrn_was_spike);
  assign nrn_is_spike     = w_nrn_out[N_MEMBRANE];
  assign nrn_new_membrane = w_nrn_out[N_MEMBRANE-1:0];

  // Reference state of the layer and scoreboard
  logic [N_INPUTS-1:0]    ref_w   [N_NEURONS];
  logic [N_THRESHOLD-1:0] ref_thr [N_NEURONS];
  logic [SHIFT_W-1:0]     ref_sh  [N_NEURONS];
  logic [N_MEMBRANE-1:0]  ref_mem [N_NEURONS];
  logic                   ref_ws  [N_NEURONS];
  int                     ref_count;
  logic [N_NEURONS-1:0]   exp_q[$];
  int                     n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_clear();
    for (int i = 0; i < N_NEURONS; i++) begin
      ref_mem[i] = '0;
      ref_ws[i]  = 1'b0;
    end
    ref_count = 0;
  endtask

  task automatic ref_reset();
    for (int i = 0; i < N_NEURONS; i++) begin
      ref_w[i]   = '0;
      ref_thr[i] = '1;
      ref_sh[i]  = '0;
    end
    ref_clear();
  endtask

  // All driver tasks start and end just after a falling edge.
  task automatic do_cfg(input logic [ADDR_W-1:0] a, input logic [N_INPUTS-1:0] w,
                        input logic [N_THRESHOLD-1:0] t, input logic [SHIFT_W-1:0] s);
    cfg_valid = 1'b1;
    cfg_addr  = a;
    cfg_data  = {w, t, s};
    #1 check("cfg_ready", cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    ref_w[a] = w; ref_thr[a] = t; ref_sh[a] = s;
  endtask

  task automatic do_step(input logic [N_INPUTS-1:0] inp, input int hold);
    logic [N_MEMBRANE-1:0] exp_last [N_NEURONS];
    logic                  exp_ws   [N_NEURONS];
    logic [N_NEURONS-1:0]  spk, held;
    logic [N_MEMBRANE:0]   r;
    int                    waited;
    for (int i = 0; i < N_NEURONS; i++) begin
      exp_last[i] = ref_mem[i];
      exp_ws[i]   = ref_ws[i];
      r = nrn_model(inp, ref_w[i], ref_sh[i], ref_thr[i], ref_mem[i], ref_ws[i]);
      ref_mem[i] = r[N_MEMBRANE-1:0];
      ref_ws[i]  = r[N_MEMBRANE];
      spk[i]     = r[N_MEMBRANE];
      if (spk[i] && ref_count < 255) ref_count++;
    end
    exp_q.push_back(spk);
    step_valid  = 1'b1;
    step_inputs = inp;
    waited = 0;
    #1;
    while (!step_ready && waited < 20) begin
      @(negedge clk);
      #1 waited++;
    end
    if (!step_ready) begin
      check("step_accept_timeout", 0, 1);
      step_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    step_valid  = 1'b0;
    step_inputs = ~inp;
    for (int k = 0; k < N_NEURONS; k++) begin
      #1;
      check("eval_state", dbg_state, EVAL);
      check("eval_out_valid", out_valid, 0);
      check("nrn_inputs", nrn_inputs, inp);
      check("nrn_weights", nrn_weights, ref_w[k]);
      check("nrn_threshold", nrn_threshold, ref_thr[k]);
      check("nrn_shift", nrn_shift, ref_sh[k]);
      check("nrn_last_membrane", nrn_last_membrane, exp_last[k]);
      check("nrn_was_spike", nrn_was_spike, exp_ws[k]);
      @(negedge clk);
    end
    #1;
    check("out_valid_latency", out_valid, 1);
    check("done_state", dbg_state, DONE);
    held = out_spikes;
    for (int h = 0; h < hold; h++) begin
      step_valid = (h == 3);
      #1;
      check("hold_spikes", out_spikes, held);
      check("hold_out_valid", out_valid, 1);
      check("hold_step_ready", step_ready, 0);
      @(negedge clk);
      step_valid = 1'b0;
    end
    out_ready = 1'b1;
    #1 check("out_spikes", out_spikes, exp_q.pop_front());
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("post_out_valid", out_valid, 0);
    check("post_state_idle", dbg_state, IDLE);
`ifdef SPIKE_COUNTER_EN
    check("spike_count", spike_count, ref_count);
`endif
  endtask

  typedef struct {
    logic clr, cv, sv;
    logic exp_cfg_ready, exp_step_ready;
  } rdy_vec_t;

  typedef struct {
    logic [N_INPUTS-1:0] inp;
  } step_vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy_vec_t  rdy_tab  [8];
    step_vec_t step_tab [6];
    for (int i = 0; i < 8; i++) begin
      rdy_tab[i].clr = i[2];
      rdy_tab[i].cv  = i[1];
      rdy_tab[i].sv  = i[0];
      rdy_tab[i].exp_cfg_ready  = !i[2];
      rdy_tab[i].exp_step_ready = !i[2] && !i[1];
    end
    step_tab[0].inp = 8'hFF; step_tab[1].inp = 8'h0F; step_tab[2].inp = 8'hAA;
    step_tab[3].inp = 8'h3C; step_tab[4].inp = 8'h00; step_tab[5].inp = 8'hF5;

    // Reset state
    ref_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_step_ready", step_ready, 1);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_state", dbg_state, IDLE);
    check("rst_out_spikes", out_spikes, 0);
    check("idle_nrn_inputs", nrn_inputs, 0);
    check("idle_nrn_threshold", nrn_threshold, 15);
    @(negedge clk);

    // Ready decoding in IDLE; inputs are withdrawn before the next rising edge
    foreach (rdy_tab[i]) begin
      clear = rdy_tab[i].clr; cfg_valid = rdy_tab[i].cv; step_valid = rdy_tab[i].sv;
      #1;
      check("tab_cfg_ready", cfg_ready, rdy_tab[i].exp_cfg_ready);
      check("tab_step_ready", step_ready, rdy_tab[i].exp_step_ready);
      clear = 1'b0; cfg_valid = 1'b0; step_valid = 1'b0;
      @(negedge clk);
    end

    // Defaults: threshold 15 and zero membranes seen for every neuron
    do_step(8'hFF, 0);

    // Neuron 2 with all weights, threshold 5: eight active inputs give membrane 8, spike
    do_cfg(2, 8'hFF, 5, 0);
    do_step(8'hFF, 2);
    check("n2_spike_vector", out_spikes, 4'b0100);
    check("idle_keeps_spikes", out_spikes, 4'b0100);

    // Long output stall with a rejected step pulse inside it
    do_step(8'hFF, 10);

    // cfg and step together: cfg wins, step is taken the following cycle
    cfg_valid = 1'b1; cfg_addr = 1; cfg_data = {8'h0F, 4'd6, 3'd1};
    step_valid = 1'b1; step_inputs = 8'h0F;
    #1;
    check("both_step_ready", step_ready, 0);
    check("both_cfg_ready", cfg_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    ref_w[1] = 8'h0F; ref_thr[1] = 4'd6; ref_sh[1] = 3'd1;
    #1 check("both_still_idle", dbg_state, IDLE);
    do_step(8'h0F, 1);

    do_cfg(0, 8'hAA, 3, 2);
    do_cfg(3, 8'h3C, 9, 1);
    foreach (step_tab[i]) do_step(step_tab[i].inp, $urandom_range(0, 3));

    // Build up membranes, then clear
    for (int i = 0; i < 3; i++) do_step(8'($urandom_range(0, 255)), 0);
    clear = 1'b1;
    #1;
    check("clear_cfg_ready", cfg_ready, 0);
    check("clear_step_ready", step_ready, 0);
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    ref_clear();
    do_step(8'h00, 0);

    // Reset while EVAL is on neuron 1
    step_valid = 1'b1; step_inputs = 8'h55;
    @(posedge clk);
    @(negedge clk);
    step_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    #1;
    check("midrst_state", dbg_state, IDLE);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_spikes", out_spikes, 0);
    check("midrst_weights", nrn_weights, 0);
    check("midrst_threshold", nrn_threshold, 15);
    @(negedge clk);
    do_step(8'hFF, 0);

`ifdef SPIKE_COUNTER_EN
    for (int i = 0; i < N_NEURONS; i++) do_cfg(ADDR_W'(i), 8'hFF, 0, 0);
    for (int i = 0; i < 300; i++) do_step(8'hFF, 0);
    check("spike_count_sat", spike_count, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
